// File: rtl/regarb_pkg.sv
// Shared constants for the register-bank arbiter: FSM encoding, data width,
// owner encoding and the round-robin pick helper.
package regarb_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_owner(input logic req_a, input logic req_b,
                                        input logic last_grant);
        if (req_a && req_b) begin
            return ~last_grant;
        end else if (req_a) begin
            return OWN_A;
        end else begin
            return OWN_B;
        end
    endfunction

endpackage

// File: rtl/reg_bank8.sv
// NREGS x 8-bit register bank: one-hot write enables, asynchronous active-low
// clear and a combinational read mux that returns zero outside the bank.
module reg_bank8
    import regarb_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREGS-1:0]  wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] bank_r [NREGS];

    // Register storage with per-register write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) begin
                    bank_r[i] <= wdata;
                end else begin
                    bank_r[i] <= bank_r[i];
                end
            end
        end
    end

    // Read mux, guarded so unpopulated addresses read as zero.
    always_comb begin
        rdata = 8'h00;
        if ({1'b0, raddr} < (AW+1)'(NREGS)) begin
            rdata = bank_r[raddr];
        end else begin
            rdata = 8'h00;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin sequencer in front of a single-port register bank.
// Optional write lock (wr_lock input, err_a/err_b outputs) under REGARB_WRLOCK_EN.
module regbank_arbiter
    import regarb_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [AW-1:0]     addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] dout_b
`ifdef REGARB_WRLOCK_EN
    ,
    input  logic              wr_lock,
    output logic              err_a,
    output logic              err_b
`endif
);

    logic [1:0]        state_r;
    logic              last_grant_r;
    logic              owner_r;
    logic              we_r;
    logic [AW-1:0]     addr_r;
    logic [DATA_W-1:0] din_r;
    logic [DATA_W-1:0] rdata_r;
    logic              ack_a_r;
    logic              ack_b_r;
    logic [DATA_W-1:0] dout_a_r;
    logic [DATA_W-1:0] dout_b_r;

    logic              grant_s;
    logic              in_range_s;
    logic              lock_s;
    logic              wr_go_s;
    logic [NREGS-1:0]  wr_en_s;
    logic [DATA_W-1:0] bank_rdata_s;
    logic [DATA_W-1:0] access_data_s;

    assign grant_s = pick_owner(req_a, req_b, last_grant_r);

    // Write-enable decode and the value captured during ACCESS.
    always_comb begin
        in_range_s = ({1'b0, addr_r} < (AW+1)'(NREGS));
        wr_go_s    = (state_r == ST_ACCESS) && we_r && in_range_s && !lock_s;
        if (wr_go_s) begin
            wr_en_s = {{(NREGS-1){1'b0}}, 1'b1} << addr_r;
        end else begin
            wr_en_s = {NREGS{1'b0}};
        end
        if (!in_range_s) begin
            access_data_s = 8'h00;
        end else if (we_r && !lock_s) begin
            access_data_s = din_r;
        end else begin
            access_data_s = bank_rdata_s;
        end
    end

    reg_bank8 #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .rst_n (reset),
        .wr_en (wr_en_s),
        .wdata (din_r),
        .raddr (addr_r),
        .rdata (bank_rdata_s)
    );

    // Sequencer: grant and latch in IDLE, access the bank, then acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= OWN_B;
            owner_r      <= OWN_A;
            we_r         <= 1'b0;
            addr_r       <= {AW{1'b0}};
            din_r        <= 8'h00;
            rdata_r      <= 8'h00;
            ack_a_r      <= 1'b0;
            ack_b_r      <= 1'b0;
            dout_a_r     <= 8'h00;
            dout_b_r     <= 8'h00;
        end else begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        owner_r <= grant_s;
                        we_r    <= (grant_s == OWN_A) ? we_a   : we_b;
                        addr_r  <= (grant_s == OWN_A) ? addr_a : addr_b;
                        din_r   <= (grant_s == OWN_A) ? din_a  : din_b;
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    rdata_r <= access_data_s;
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    if (owner_r == OWN_A) begin
                        ack_a_r  <= 1'b1;
                        dout_a_r <= rdata_r;
                    end else begin
                        ack_b_r  <= 1'b1;
                        dout_b_r <= rdata_r;
                    end
                    last_grant_r <= owner_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_a  = ack_a_r;
    assign ack_b  = ack_b_r;
    assign dout_a = dout_a_r;
    assign dout_b = dout_b_r;

`ifdef REGARB_WRLOCK_EN
    logic lock_r;
    logic err_a_r;
    logic err_b_r;

    assign lock_s = lock_r;

    // Lock is sampled with the grant; err flags a suppressed write at ack time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r  <= 1'b0;
            err_a_r <= 1'b0;
            err_b_r <= 1'b0;
        end else begin
            err_a_r <= 1'b0;
            err_b_r <= 1'b0;
            if ((state_r == ST_IDLE) && (req_a || req_b)) begin
                lock_r <= wr_lock;
            end else if (state_r == ST_ACK) begin
                err_a_r <= lock_r && we_r && (owner_r == OWN_A);
                err_b_r <= lock_r && we_r && (owner_r == OWN_B);
            end else begin
                lock_r <= lock_r;
            end
        end
    end

    assign err_a = err_a_r;
    assign err_b = err_b_r;
`else
    assign lock_s = 1'b0;
`endif

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: transaction-level model, directed
// scenarios with literal expectations, then randomized two-requester traffic.
module tb_regbank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, we_a, req_b, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] din_a, din_b, dout_a, dout_b;
    logic       ack_a, ack_b;
`ifdef REGARB_WRLOCK_EN
    logic       wr_lock, err_a, err_b;
    logic       exp_err_a, exp_err_b, merr;
`endif

    always #5 clk = ~clk;

    regbank_arbiter #(.NREGS(8), .AW(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .ack_a  (ack_a),
        .dout_a (dout_a),
        .req_b  (req_b),
        .we_b   (we_b),
        .addr_b (addr_b),
        .din_b  (din_b),
        .ack_b  (ack_b),
        .dout_b (dout_b)
`ifdef REGARB_WRLOCK_EN
        ,
        .wr_lock(wr_lock),
        .err_a  (err_a),
        .err_b  (err_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    logic [7:0] mbank [8];
    bit         mlast;
    bit         mbusy;
    bit         mowner;
    int         cyc;
    int         mdue;
    logic [7:0] mval;
    logic       exp_ack_a, exp_ack_b;
    logic [7:0] exp_dout_a, exp_dout_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbank[i] = 8'h00;
        mlast = 1'b1;
        mbusy = 1'b0;
        exp_ack_a = 1'b0;
        exp_ack_b = 1'b0;
        exp_dout_a = 8'h00;
        exp_dout_b = 8'h00;
`ifdef REGARB_WRLOCK_EN
        exp_err_a = 1'b0;
        exp_err_b = 1'b0;
        merr = 1'b0;
`endif
    endtask

    // A grant at edge k completes (ack visible) after edge k+2; no new grant until k+3.
    task automatic model_step();
        bit own, w, lk;
        logic [2:0] a;
        logic [7:0] d;
        cyc++;
        exp_ack_a = 1'b0;
        exp_ack_b = 1'b0;
`ifdef REGARB_WRLOCK_EN
        exp_err_a = 1'b0;
        exp_err_b = 1'b0;
`endif
        if (mbusy) begin
            if (cyc == mdue) begin
                mbusy = 1'b0;
                mlast = mowner;
                if (mowner) begin
                    exp_ack_b = 1'b1;
                    exp_dout_b = mval;
                end else begin
                    exp_ack_a = 1'b1;
                    exp_dout_a = mval;
                end
`ifdef REGARB_WRLOCK_EN
                if (mowner) exp_err_b = merr;
                else        exp_err_a = merr;
`endif
            end
        end else if (req_a || req_b) begin
            if (req_a && req_b) own = !mlast;
            else                own = req_b;
            w = own ? we_b : we_a;
            a = own ? addr_b : addr_a;
            d = own ? din_b : din_a;
            lk = 1'b0;
`ifdef REGARB_WRLOCK_EN
            lk = wr_lock;
            merr = w && lk;
`endif
            if (w && !lk) begin
                mbank[a] = d;
                mval = d;
            end else begin
                mval = mbank[a];
            end
            mowner = own;
            mbusy = 1'b1;
            mdue = cyc + 2;
        end
    endtask

    task automatic compare();
        chk("ack_a", 32'(ack_a), 32'(exp_ack_a));
        chk("ack_b", 32'(ack_b), 32'(exp_ack_b));
        chk("dout_a", 32'(dout_a), 32'(exp_dout_a));
        chk("dout_b", 32'(dout_b), 32'(exp_dout_b));
        chk("ack_excl", 32'(ack_a & ack_b), 32'd0);
`ifdef REGARB_WRLOCK_EN
        chk("err_a", 32'(err_a), 32'(exp_err_a));
        chk("err_b", 32'(err_b), 32'(exp_err_b));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic do_txn(input bit side, input bit w, input logic [2:0] a,
                          input logic [7:0] d, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        if (side) begin
            req_b = 1'b1; we_b = w; addr_b = a; din_b = d;
        end else begin
            req_a = 1'b1; we_a = w; addr_a = a; din_a = d;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            got = side ? exp_ack_b : exp_ack_a;
        end
        chk("txn_done", 32'(got), 32'd1);
        if (side) req_b = 1'b0;
        else      req_a = 1'b0;
    endtask

    initial begin
        int lat, ta, tb, n, prev;
        reset = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 3'd0; din_a = 8'h00;
        req_b = 1'b0; we_b = 1'b0; addr_b = 3'd0; din_b = 8'h00;
`ifdef REGARB_WRLOCK_EN
        wr_lock = 1'b0;
`endif
        cyc = 0;
        model_reset();
        tick();
        tick();
        chk("rst_dout_a", 32'(dout_a), 32'h00);
        chk("rst_dout_b", 32'(dout_b), 32'h00);
        chk("rst_acks", 32'({ack_a, ack_b}), 32'd0);
        reset = 1'b1;

        // Every address reads zero after reset
        for (int i = 0; i < 8; i++) begin
            do_txn(i[0], 1'b0, 3'(i), 8'h00, lat);
            chk("t1_read_zero", 32'(i[0] ? dout_b : dout_a), 32'h00);
        end

        // A write then B read of the same address
        do_txn(1'b0, 1'b1, 3'd3, 8'hA5, lat);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_dout_a", 32'(dout_a), 32'hA5);
        do_txn(1'b1, 1'b0, 3'd3, 8'h00, lat);
        chk("t2_dout_b", 32'(dout_b), 32'hA5);
        chk("t2_dout_a_held", 32'(dout_a), 32'hA5);

        // Simultaneous first requests: A wins, B follows
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; din_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; din_b = 8'h22;
        ta = 0;
        tb = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (exp_ack_a && ta == 0) begin ta = t; req_a = 1'b0; end
            if (exp_ack_b && tb == 0) begin tb = t; req_b = 1'b0; end
        end
        chk("t3_a_first", 32'(ta), 32'd3);
        chk("t3_b_second", 32'(tb), 32'd6);
        chk("t3_dout_a", 32'(dout_a), 32'h11);
        chk("t3_dout_b", 32'(dout_b), 32'h22);
        do_txn(1'b0, 1'b0, 3'd1, 8'h00, lat);
        chk("t3_final", 32'(dout_a), 32'h22);

        // Continuous requests from both alternate A, B, ... every 3 cycles
        do_reset();
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd5;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd6;
        n = 0;
        prev = 0;
        for (int t = 1; t <= 40 && n < 6; t++) begin
            tick();
            if (exp_ack_a || exp_ack_b) begin
                chk("t4_order", 32'({ack_a, ack_b}), (n % 2 == 1) ? 32'd1 : 32'd2);
                chk("t4_spacing", 32'(t - prev), 32'd3);
                prev = t;
                n++;
            end
        end
        chk("t4_count", 32'(n), 32'd6);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();

        // Reset during ACCESS of a write: no ack, data lost
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd2; din_a = 8'hFF;
        tick();
        reset = 1'b0;
        req_a = 1'b0;
        model_reset();
        tick();
        tick();
        chk("t5_no_ack", 32'(ack_a), 32'd0);
        reset = 1'b1;
        do_txn(1'b0, 1'b0, 3'd2, 8'h00, lat);
        chk("t5_readback", 32'(dout_a), 32'h00);

`ifdef REGARB_WRLOCK_EN
        // Locked write is suppressed and flagged
        do_txn(1'b1, 1'b1, 3'd0, 8'h5A, lat);
        wr_lock = 1'b1;
        do_txn(1'b1, 1'b1, 3'd0, 8'h3C, lat);
        chk("t6_err_b", 32'(err_b), 32'd1);
        chk("t6_ack_b", 32'(ack_b), 32'd1);
        chk("t6_dout_b", 32'(dout_b), 32'h5A);
        wr_lock = 1'b0;
        do_txn(1'b0, 1'b0, 3'd0, 8'h00, lat);
        chk("t6_kept", 32'(dout_a), 32'h5A);
`endif

        // Randomized traffic: hold a request until its ack, then maybe reissue
        for (int c = 0; c < 600; c++) begin
            if (!req_a || exp_ack_a) begin
                req_a  = 1'($urandom_range(1, 0));
                we_a   = 1'($urandom_range(1, 0));
                addr_a = 3'($urandom_range(7, 0));
                din_a  = 8'($urandom);
            end
            if (!req_b || exp_ack_b) begin
                req_b  = 1'($urandom_range(1, 0));
                we_b   = 1'($urandom_range(1, 0));
                addr_b = 3'($urandom_range(7, 0));
                din_b  = 8'($urandom);
            end
`ifdef REGARB_WRLOCK_EN
            wr_lock = ($urandom_range(3, 0) == 0);
`endif
            tick();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
